add_round_key_stream: RTL and testbench
=======================================

Name: add_round_key_stream

Overview:
Parametrised, streaming successor to the single-register AddRoundKey stage. It holds a small round-key file written by the key-expansion logic. Each accepted state word is XORed with the key selected by its round index. The result goes into a DEPTH-entry output FIFO with valid/ready handshakes on both sides, so the cipher datapath can stall without losing data. It sits between the MixColumns/ShiftRows stage and the next round stage, or the output register.

Parameters:
DATA_W, 128, state/key width in bits; bit 0 is the MSB (vectors declared [0:DATA_W-1]).
NUM_KEYS, 11, number of round-key slots (11 = AES-128, 15 = AES-256).
IDX_W, 4, width of round-index fields; must satisfy 2^IDX_W >= NUM_KEYS.
DEPTH, 2, output FIFO depth in entries; legal range 1..8.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  asynchronous, active-high reset.
key_wr_en  in  1  write key_wr_data into slot key_wr_idx this cycle.
key_wr_idx  in  IDX_W  key slot to write.
key_wr_data  in  DATA_W  round key value.
in_valid  in  1  input word present.
in_ready  out  1  block can accept a word.
in_data  in  [0:DATA_W-1]  state word.
in_round  in  IDX_W  key slot to apply.
in_last  in  1  final round of a block; carried through to the output.
out_valid  out  1  FIFO head valid.
out_ready  in  1  downstream accepts the head.
out_data  out  [0:DATA_W-1]  in_data XOR key[in_round].
out_round  out  IDX_W  round index carried with the word.
out_last  out  1  in_last carried with the word.
idx_err  out  1  sticky flag: an out-of-range index was used.
err_clr  in  1  synchronous clear of idx_err.
fifo_count  out  $clog2(DEPTH+1)  number of FIFO entries occupied.

Behaviour:
- Reset (asynchronous, effective immediately, from any state):
  - all key slots = 0; FIFO emptied; fifo_count = 0.
  - out_valid = 0, out_data = 0, out_round = 0, out_last = 0, idx_err = 0.
  - in_ready = 0 while reset is high; in_ready = 1 on the first cycle after deassertion.
  - reset mid-stream discards all FIFO contents; no partial output appears after reset.
- Input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
- in_ready = (fifo_count < DEPTH). It is registered-state only: no combinational path from out_ready to in_ready.
- Latency: a word accepted at edge N is visible at the head no earlier than after edge N, i.e. out_valid rises in the cycle following acceptance when the FIFO was empty. One cycle minimum latency; throughput one word per cycle when out_ready is held high.
- XOR is computed at acceptance from the key value held before that edge.
- Key write to the same slot in the same cycle: the transfer uses the old key; the new key applies from the next cycle on.
- Key writes are never blocked by stalls.
- key_wr_idx >= NUM_KEYS: the write is ignored and idx_err is set.
- in_round >= NUM_KEYS on an accepted word: the word passes with key = 0 (out_data = in_data) and idx_err is set.
- idx_err is sticky; cleared by reset or err_clr. If err_clr and a new error occur in the same cycle, the set wins.
- FIFO ordering is strict in-order.
  - head outputs (out_data/round/last) are stable while out_valid = 1 and out_ready = 0.
  - simultaneous input and output transfer while full: not possible, since in_ready = 0.
  - simultaneous transfers while partially full: count unchanged, both transfers succeed.
  - empty: out_valid = 0; out_data holds its last value (don't-care to checker).
- fifo_count = accepted − drained, saturating at DEPTH by construction. Pointers wrap modulo DEPTH; DEPTH is not required to be a power of 2.
- The upstream must hold in_valid and its payload until accepted; the block does not re-check this.

Test Plan:
- Basic transfer, FIPS-197 round 0:
  - write slot 0 = 000102030405060708090a0b0c0d0e0f; send in_data = 00112233445566778899aabbccddeeff, in_round = 0, out_ready = 1.
  - required: out_data = 00102030405060708090a0b0c0d0e0f0, out_valid high exactly one cycle after acceptance.
- Backpressure, DEPTH = 2:
  - hold out_ready = 0 and offer 3 words with keys 1, 2, 3.
  - required: in_ready falls after 2 acceptances; fifo_count = 2; head stable.
  - then raise out_ready: all 3 words emerge in order with no loss or duplication; fifo_count returns to 0.
- Same-cycle key write hazard:
  - slot 5 = AA..AA; in the same cycle, write slot 5 = 55..55 and accept in_data = 0 with round 5.
  - required: out = AA..AA. The next word, 0 with round 5, gives out = 55..55.
- Out-of-range index:
  - in_round = 12 with NUM_KEYS = 11 → out_data = in_data, idx_err = 1, stays 1 across further good words.
  - err_clr → idx_err = 0 next cycle.
  - err_clr together with a bad key_wr_idx = 15 → idx_err stays 1.
- Asynchronous reset mid-stream:
  - FIFO holding 2 words; assert reset between clock edges.
  - required: out_valid = 0 and idx_err = 0 immediately, fifo_count = 0, keys read back as 0 (word 0 round 0 → out 0), no stale word after release.
- Streaming throughput:
  - 11 consecutive words, rounds 0–10 with in_last on round 10, out_ready = 1.
  - required: 11 outputs on 11 consecutive cycles; out_last high only on the 11th; out_round = 0..10 in order.

Source files
------------

// File: rtl/add_round_key_stream.sv
// add_round_key_stream: streaming AddRoundKey stage.
// Each accepted state word is XORed with the round key chosen by its round
// index. The result is queued in a small output FIFO so the downstream round
// can stall without dropping words. Round keys sit in a register file that
// the key-expansion logic writes.
module add_round_key_stream #(
  parameter int DATA_W   = 128,
  parameter int NUM_KEYS = 11,
  parameter int IDX_W    = 4,
  parameter int DEPTH    = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         key_wr_en,
  input  logic [IDX_W-1:0]             key_wr_idx,
  input  logic [0:DATA_W-1]            key_wr_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [0:DATA_W-1]            in_data,
  input  logic [IDX_W-1:0]             in_round,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [0:DATA_W-1]            out_data,
  output logic [IDX_W-1:0]             out_round,
  output logic                         out_last,
  output logic                         idx_err,
  input  logic                         err_clr,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);
  // One extra bit so NUM_KEYS itself is representable for range checks.
  localparam logic [IDX_W:0] NK = (IDX_W+1)'(NUM_KEYS);

  typedef struct packed {
    logic [0:DATA_W-1] data;
    logic [IDX_W-1:0]  round;
    logic              last;
  } ent_t;

  logic [0:DATA_W-1] key_q [NUM_KEYS];
  ent_t              mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [0:DATA_W-1] key_sel;
  logic              push, pop;
  logic              wr_bad, rd_bad;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // Ready depends only on registered occupancy (and reset), never on out_ready.
  assign in_ready   = ~reset & (cnt_q < CNT_W'(DEPTH));
  assign out_valid  = (cnt_q != '0);
  assign push       = in_valid & in_ready;
  assign pop        = out_valid & out_ready;
  assign wr_bad     = key_wr_en & ({1'b0, key_wr_idx} >= NK);
  assign rd_bad     = push & ({1'b0, in_round} >= NK);

  assign out_data   = mem_q[rd_ptr_q].data;
  assign out_round  = mem_q[rd_ptr_q].round;
  assign out_last   = mem_q[rd_ptr_q].last;
  assign idx_err    = err_q;
  assign fifo_count = cnt_q;

  // Key lookup; an out-of-range round matches no slot and yields key 0.
  always_comb begin
    key_sel = '0;
    for (int k = 0; k < NUM_KEYS; k++)
      if (in_round == IDX_W'(k)) key_sel = key_q[k];
  end

  // Pointer, occupancy and sticky-error next state.
  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    err_d = err_q;
    if (wr_bad || rd_bad) err_d = 1'b1;
    else if (err_clr)     err_d = 1'b0;
  end

  // Round-key file; writes to nonexistent slots are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_KEYS; k++) key_q[k] <= '0;
    end else if (key_wr_en) begin
      for (int k = 0; k < NUM_KEYS; k++)
        if (key_wr_idx == IDX_W'(k)) key_q[k] <= key_wr_data;
    end
  end

  // FIFO storage; XOR uses the key held before this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= '{data: in_data ^ key_sel, round: in_round, last: in_last};
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_add_round_key_stream.sv
// Bench for add_round_key_stream: reset checks, a vector table, directed
// multi-cycle corner cases and a randomized run against a queue-based model.
module tb_add_round_key_stream;
  localparam int NK = 11;
  localparam int DP = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         key_wr_en;
  logic [3:0]   key_wr_idx;
  logic [0:127] key_wr_data;
  logic         in_valid, in_ready;
  logic [0:127] in_data;
  logic [3:0]   in_round;
  logic         in_last;
  logic         out_valid, out_ready;
  logic [0:127] out_data;
  logic [3:0]   out_round;
  logic         out_last;
  logic         idx_err, err_clr;
  logic [1:0]   fifo_count;

  add_round_key_stream #(.DATA_W(128), .NUM_KEYS(NK), .IDX_W(4), .DEPTH(DP)) dut (
    .clk(clk), .reset(reset),
    .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx), .key_wr_data(key_wr_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_round(in_round), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_round(out_round), .out_last(out_last),
    .idx_err(idx_err), .err_clr(err_clr), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [0:127] d; logic [3:0] r; logic l; } ent_t;
  typedef struct {
    bit wr; logic [3:0] widx; logic [0:127] wkey;
    logic [0:127] din; logic [3:0] rnd; bit last;
    logic [0:127] exp; bit experr;
  } vec_t;

  // Reference model: key slots, word queue, sticky error.
  logic [0:127] rk [16];
  ent_t         mq [$];
  bit           rerr;
  bit           last_acc;
  int           total = 0;
  int           bad   = 0;
  vec_t         tbl [4];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) rk[i] = '0;
    mq.delete();
    rerr = 1'b0;
  endtask

  task automatic mcheck();
    chk("in_ready",   in_ready,   128'(mq.size() < DP));
    chk("out_valid",  out_valid,  128'(mq.size() > 0));
    chk("fifo_count", fifo_count, 128'(mq.size()));
    chk("idx_err",    idx_err,    128'(rerr));
    if (mq.size() > 0) begin
      chk("head_data",  out_data,  mq[0].d);
      chk("head_round", out_round, mq[0].r);
      chk("head_last",  out_last,  mq[0].l);
    end
  endtask

  // One clock: predict from pre-edge inputs, advance, then compare.
  task automatic tick();
    bit acc, pop, set;
    logic [0:127] k;
    ent_t dump;
    acc = in_valid && (mq.size() < DP);
    pop = out_ready && (mq.size() > 0);
    k   = (int'(in_round) < NK) ? rk[in_round] : '0;
    @(posedge clk); #1;
    if (pop) dump = mq.pop_front();
    if (acc) mq.push_back('{d: in_data ^ k, r: in_round, l: in_last});
    set = (key_wr_en && int'(key_wr_idx) >= NK) || (acc && int'(in_round) >= NK);
    if (set) rerr = 1'b1;
    else if (err_clr) rerr = 1'b0;
    if (key_wr_en && int'(key_wr_idx) < NK) rk[key_wr_idx] = key_wr_data;
    last_acc = acc;
    mcheck();
  endtask

  function automatic logic [0:127] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [0:127] w;
    tbl[0] = '{1'b1, 4'd0,  128'h000102030405060708090a0b0c0d0e0f,
               128'h00112233445566778899aabbccddeeff, 4'd0, 1'b0,
               128'h00102030405060708090a0b0c0d0e0f0, 1'b0};
    tbl[1] = '{1'b1, 4'd10, {128{1'b1}},
               128'h0123456789abcdef0123456789abcdef, 4'd10, 1'b1,
               128'hfedcba9876543210fedcba9876543210, 1'b0};
    tbl[2] = '{1'b1, 4'd3,  {16{8'h0f}}, {16{8'hf0}}, 4'd3, 1'b0,
               {16{8'hff}}, 1'b0};
    tbl[3] = '{1'b0, 4'd0,  '0,
               128'hdeadbeefcafef00d0123456789abcdef, 4'd12, 1'b0,
               128'hdeadbeefcafef00d0123456789abcdef, 1'b1};

    reset = 1'b1; key_wr_en = 0; key_wr_idx = 0; key_wr_data = '0;
    in_valid = 0; in_data = '0; in_round = 0; in_last = 0;
    out_ready = 0; err_clr = 0;
    model_reset();
    #12;
    // Reset state.
    chk("rst in_ready",   in_ready,   0);
    chk("rst out_valid",  out_valid,  0);
    chk("rst out_data",   out_data,   0);
    chk("rst out_round",  out_round,  0);
    chk("rst out_last",   out_last,   0);
    chk("rst idx_err",    idx_err,    0);
    chk("rst fifo_count", fifo_count, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("post-rst in_ready", in_ready, 1);

    // Vector table: one word at a time into an empty FIFO.
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      if (tbl[i].wr) begin
        key_wr_en = 1; key_wr_idx = tbl[i].widx; key_wr_data = tbl[i].wkey;
        tick();
        key_wr_en = 0;
      end
      in_valid = 1; in_data = tbl[i].din; in_round = tbl[i].rnd; in_last = tbl[i].last;
      chk("tbl pre out_valid", out_valid, 0);
      tick();
      in_valid = 0;
      chk("tbl out_valid", out_valid, 1);
      chk("tbl out_data",  out_data,  tbl[i].exp);
      chk("tbl out_round", out_round, tbl[i].rnd);
      chk("tbl out_last",  out_last,  tbl[i].last);
      chk("tbl idx_err",   idx_err,   tbl[i].experr);
      tick();
    end
    err_clr = 1; tick(); err_clr = 0;
    chk("tbl err cleared", idx_err, 0);

    // Backpressure: three words into a two-entry FIFO.
    for (int s = 1; s <= 3; s++) begin
      key_wr_en = 1; key_wr_idx = 4'(s); key_wr_data = rnd128(); tick();
    end
    key_wr_en = 0; out_ready = 0;
    for (int s = 1; s <= 3; s++) begin
      in_valid = 1; in_data = rnd128(); in_round = 4'(s); in_last = 0;
      tick();
      if (s == 3) begin tick(); tick(); end
      if (s < 3) chk("bp accepted", last_acc, 1);
    end
    chk("bp full count", fifo_count, 2);
    chk("bp in_ready",   in_ready,   0);
    chk("bp head round", out_round,  1);
    out_ready = 1;
    tick();
    chk("bp 2nd head", out_round, 2);
    tick();
    chk("bp 3rd acc",  last_acc, 1);
    chk("bp 3rd head", out_round, 3);
    in_valid = 0;
    tick();
    chk("bp drained", fifo_count, 0);

    // Same-cycle key write hazard.
    key_wr_en = 1; key_wr_idx = 5; key_wr_data = {16{8'hAA}}; tick();
    key_wr_data = {16{8'h55}};
    in_valid = 1; in_data = '0; in_round = 5; in_last = 0;
    tick();
    key_wr_en = 0;
    chk("hazard old key", out_data, {16{8'hAA}});
    tick();
    in_valid = 0;
    chk("hazard new key", out_data, {16{8'h55}});
    tick();

    // Out-of-range index, sticky error and clear priority.
    w = rnd128();
    in_valid = 1; in_data = w; in_round = 12; tick();
    chk("oor passthru", out_data, w);
    chk("oor err set",  idx_err,  1);
    in_round = 0; in_data = rnd128(); tick();
    in_valid = 0;
    chk("oor sticky", idx_err, 1);
    err_clr = 1; tick();
    chk("oor cleared", idx_err, 0);
    key_wr_en = 1; key_wr_idx = 15; key_wr_data = rnd128(); tick();
    chk("set beats clr", idx_err, 1);
    key_wr_en = 0; tick();
    err_clr = 0;

    // Asynchronous reset with a full FIFO and a pending error.
    out_ready = 0; in_valid = 1;
    in_data = rnd128(); in_round = 12; tick();
    in_data = rnd128(); in_round = 1;  tick();
    in_valid = 0;
    chk("pre-rst count", fifo_count, 2);
    chk("pre-rst err",   idx_err,    1);
    #3; reset = 1; #1;
    chk("async out_valid", out_valid,  0);
    chk("async idx_err",   idx_err,    0);
    chk("async count",     fifo_count, 0);
    chk("async in_ready",  in_ready,   0);
    model_reset();
    @(posedge clk); #1;
    reset = 0;
    out_ready = 1;
    tick();
    chk("no stale word", out_valid, 0);
    in_valid = 1; in_data = '0; in_round = 0; tick();
    in_valid = 0;
    chk("key0 after rst", out_data, 0);
    tick();

    // Streaming: rounds 0..10 back to back.
    for (int s = 0; s < NK; s++) begin
      key_wr_en = 1; key_wr_idx = 4'(s); key_wr_data = rnd128(); tick();
    end
    key_wr_en = 0;
    for (int s = 0; s < NK; s++) begin
      in_valid = 1; in_data = rnd128(); in_round = 4'(s); in_last = (s == NK-1);
      tick();
      chk("stream valid", out_valid, 1);
      chk("stream round", out_round, s);
      chk("stream last",  out_last,  s == NK-1);
    end
    in_valid = 0; in_last = 0;
    tick();
    chk("stream end", out_valid, 0);

    // Randomized run against the model.
    last_acc = 1;
    for (int c = 0; c < 3000; c++) begin
      if (!(in_valid && !last_acc)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = rnd128();
        in_round = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(11, 15))
                                               : 4'($urandom_range(0, 10));
        in_last  = ($urandom_range(0, 7) == 0);
      end
      out_ready   = ($urandom_range(0, 2) != 0);
      key_wr_en   = ($urandom_range(0, 3) == 0);
      key_wr_idx  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(11, 15))
                                                : 4'($urandom_range(0, 10));
      key_wr_data = rnd128();
      err_clr     = ($urandom_range(0, 15) == 0);
      tick();
    end
    in_valid = 0; key_wr_en = 0; err_clr = 0; out_ready = 1;
    tick(); tick(); tick();
    chk("rand drained", fifo_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
